// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, ALU codes, IR fields, states.
// MULDIV_EN adds the MUL/DIV opcodes and the extra T6 execute state.
package cpu_ctrl_pkg;

  localparam int OPC_W  = 5;
  localparam int REG_W  = 4;
  localparam int OPC_LO = 27;
  localparam int RA_LO  = 23;
  localparam int RB_LO  = 19;
  localparam int RC_LO  = 15;

  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  localparam logic [OPC_W-1:0] ALU_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] ALU_SUB  = 5'b00101;
  localparam logic [OPC_W-1:0] ALU_AND  = 5'b00110;
  localparam logic [OPC_W-1:0] ALU_OR   = 5'b00111;
  localparam logic [OPC_W-1:0] ALU_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] ALU_DIV  = 5'b10000;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5,
`ifdef MULDIV_EN
    S_T6,
`endif
    S_HALT
  } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Pure combinational opcode classifier and ALU OP mapping.
// MULDIV_EN makes MUL/DIV legal; otherwise they fall into the undefined class.
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             legal,
  output logic             is_nop,
  output logic             is_halt,
  output logic             is_muldiv,
  output logic [OPC_W-1:0] op
);

  always_comb begin
    legal     = 1'b0;
    is_nop    = 1'b0;
    is_halt   = 1'b0;
    is_muldiv = 1'b0;
    op        = '0;
    case (opcode)
      OPC_ADD:  begin legal = 1'b1; op = ALU_ADD; end
      OPC_SUB:  begin legal = 1'b1; op = ALU_SUB; end
      OPC_AND:  begin legal = 1'b1; op = ALU_AND; end
      OPC_OR:   begin legal = 1'b1; op = ALU_OR;  end
`ifdef MULDIV_EN
      OPC_MUL:  begin legal = 1'b1; is_muldiv = 1'b1; op = ALU_MUL; end
      OPC_DIV:  begin legal = 1'b1; is_muldiv = 1'b1; op = ALU_DIV; end
`endif
      OPC_NOP:  is_nop  = 1'b1;
      OPC_HALT: is_halt = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer driving datapath strobes for 3-register ALU instructions.
// MULDIV_EN enables MUL/DIV with a 7-cycle sequence through T6 (HI/LO writeback).
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5,
  parameter int WAIT_MAX = 15
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic [31:0]         IR,
  input  logic                Mem_ready,
  input  logic                Stop,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin,
  output logic                ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin,
  output logic [OP_W-1:0]     OP,
  output logic                Run,
  output logic                Illegal,
  output logic                MemTimeout
);

  localparam int CW = $clog2(WAIT_MAX);

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt;
  logic            stop_lat, illegal_q, timeout_q;
  logic            legal, is_nop, is_halt, is_muldiv;
  logic [OPC_W-1:0] dec_op;
  logic [REG_W-1:0] ra, rb, rc;
  logic            stop_any, wait_expire, undef_op;

  assign ra = IR[RA_LO +: REG_W];
  assign rb = IR[RB_LO +: REG_W];
  assign rc = IR[RC_LO +: REG_W];
  wire unused_ir = ^IR[RC_LO-1:0];

  instr_decoder u_dec (
    .opcode    (IR[OPC_LO +: OPC_W]),
    .legal     (legal),
    .is_nop    (is_nop),
    .is_halt   (is_halt),
    .is_muldiv (is_muldiv),
    .op        (dec_op)
  );

  // A Stop arriving in the final cycle still counts for that boundary.
  assign stop_any    = stop_lat | Stop;
  assign wait_expire = (state == S_T1) && !Mem_ready && (wait_cnt == CW'(WAIT_MAX - 1));
  assign undef_op    = !legal && !is_nop && !is_halt;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state     <= S_RST;
      wait_cnt  <= '0;
      stop_lat  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (Stop) stop_lat <= 1'b1;
      if (state == S_T1 && !Mem_ready) wait_cnt <= wait_cnt + CW'(1);
      else                             wait_cnt <= '0;
      if (wait_expire) timeout_q <= 1'b1;
      if (state == S_T3 && undef_op) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    Rin = '0; Rout = '0; OP = '0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; Read = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; ZLowin = 1'b0; ZHighin = 1'b0;
    ZLowout = 1'b0; ZHighout = 1'b0; HIin = 1'b0; LOin = 1'b0;
    case (state)
      S_RST: state_nxt = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        Read = 1'b1; MDRin = 1'b1;
        if (Mem_ready) begin
          PCin = 1'b1;
          state_nxt = S_T2;
        end else if (wait_expire) begin
          state_nxt = S_HALT;
        end
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        if (legal) begin
          Yin = 1'b1;
          if (is_muldiv) Rout[ra] = 1'b1;
          else           Rout[rb] = 1'b1;
          state_nxt = S_T4;
        end else if (is_halt) begin
          state_nxt = S_HALT;
        end else begin
          // NOP and undefined opcodes both end the instruction here.
          state_nxt = stop_any ? S_HALT : S_T0;
        end
      end
      S_T4: begin
        ZLowin = 1'b1;
        OP     = OP_W'(dec_op);
        if (is_muldiv) begin
          Rout[rb] = 1'b1;
          ZHighin  = 1'b1;
        end else begin
          Rout[rc] = 1'b1;
        end
        state_nxt = S_T5;
      end
      S_T5: begin
        ZLowout = 1'b1;
`ifdef MULDIV_EN
        if (is_muldiv) begin
          LOin      = 1'b1;
          state_nxt = S_T6;
        end else
`endif
        begin
          Rin[ra]   = 1'b1;
          state_nxt = stop_any ? S_HALT : S_T0;
        end
      end
`ifdef MULDIV_EN
      S_T6: begin
        ZHighout  = 1'b1;
        HIin      = 1'b1;
        state_nxt = stop_any ? S_HALT : S_T0;
      end
`endif
      S_HALT: ;
      default: state_nxt = S_RST;
    endcase
  end

  assign Run        = (state != S_RST) && (state != S_HALT);
  assign Illegal    = illegal_q;
  assign MemTimeout = timeout_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; honours MULDIV_EN for the MUL case.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic        Mem_ready = 1'b0;
  logic        Stop = 1'b0;
  logic [31:0] IR = '0;
  logic [15:0] Rin, Rout;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
  logic        ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin;
  logic [4:0]  OP;
  logic        Run, Illegal, MemTimeout;

  int n_cmp = 0;
  int n_bad = 0;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
    .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowin(ZLowin), .ZHighin(ZHighin),
    .ZLowout(ZLowout), .ZHighout(ZHighout), .HIin(HIin), .LOin(LOin),
    .OP(OP), .Run(Run), .Illegal(Illegal), .MemTimeout(MemTimeout)
  );

  always #5 Clock = ~Clock;

  logic [14:0] strb;
  assign strb = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin,
                 ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin};

  localparam logic [14:0] B_PCOUT = 15'h4000, B_PCIN  = 15'h2000, B_INCPC = 15'h1000;
  localparam logic [14:0] B_MARIN = 15'h0800, B_READ  = 15'h0400, B_MDRIN = 15'h0200;
  localparam logic [14:0] B_MDROUT= 15'h0100, B_IRIN  = 15'h0080, B_YIN   = 15'h0040;
  localparam logic [14:0] B_ZLIN  = 15'h0020, B_ZLOUT = 15'h0008;
  localparam logic [14:0] B_T0    = B_PCOUT | B_MARIN | B_INCPC;

  // per-instruction observations collected by run_instr
  int          r_cyc, r_read, r_pcin, r_pcin_last, r_rin_n, r_lo, r_hi;
  logic [15:0] r_rin_last;
  logic [4:0]  r_op;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic [14:0] s, input logic [15:0] ri,
                            input logic [15:0] ro, input logic [4:0] op, input logic run);
    chk({tag, "_strb"}, 32'(strb), 32'(s));
    chk({tag, "_rin"},  32'(Rin),  32'(ri));
    chk({tag, "_rout"}, 32'(Rout), 32'(ro));
    chk({tag, "_op"},   32'(OP),   32'(op));
    chk({tag, "_run"},  32'(Run),  32'(run));
  endtask

  // Starts in T0; runs until the next T0 or until Run drops.
  task automatic run_instr(input int mem_wait, input int stop_cyc);
    int t1 = 0;
    r_cyc = 0; r_read = 0; r_pcin = 0; r_pcin_last = 0; r_rin_n = 0;
    r_lo = 0; r_hi = 0; r_rin_last = '0; r_op = '0;
    do begin
      Stop      = (r_cyc == stop_cyc);
      Mem_ready = (t1 >= mem_wait);
      #1;
      if (Read) begin r_read++; t1++; r_pcin_last = int'(PCin); end
      if (PCin) r_pcin++;
      if (Rin != '0) begin r_rin_n++; r_rin_last = Rin; end
      if (LOin) r_lo++;
      if (HIin) r_hi++;
      if (ZLowin) r_op = OP;
      r_cyc++;
      @(posedge Clock);
      #1;
    end while (Run && !(PCout && MARin) && r_cyc < 60);
    Stop = 1'b0;
    Mem_ready = 1'b1;
    if (r_cyc >= 60) chk("cycle_bound", 32'(r_cyc), 32'd59);
  endtask

  task automatic do_clear();
    Clear = 1'b1; tick(); Clear = 1'b0;
  endtask

  initial begin
    // reset state
    Mem_ready = 1'b1;
    IR = 32'h1822_8000;
    tick(); tick();
    expect_cyc("rst", '0, '0, '0, '0, 1'b0);
    chk("rst_illegal", 32'(Illegal), 0);
    chk("rst_timeout", 32'(MemTimeout), 0);
    Clear = 1'b0; tick();

    // add R0,R4,R5 cycle by cycle
    expect_cyc("add_t0", B_T0, '0, '0, '0, 1'b1); tick();
    expect_cyc("add_t1", B_READ | B_MDRIN | B_PCIN, '0, '0, '0, 1'b1); tick();
    expect_cyc("add_t2", B_MDROUT | B_IRIN, '0, '0, '0, 1'b1); tick();
    expect_cyc("add_t3", B_YIN, '0, 16'h0010, '0, 1'b1); tick();
    expect_cyc("add_t4", B_ZLIN, '0, 16'h0020, 5'b00100, 1'b1); tick();
    expect_cyc("add_t5", B_ZLOUT, 16'h0001, '0, '0, 1'b1); tick();
    expect_cyc("add_t0_next", B_T0, '0, '0, '0, 1'b1);

    // three memory wait cycles
    run_instr(3, -1);
    chk("wait_cycles", 32'(r_cyc), 9);
    chk("wait_reads", 32'(r_read), 4);
    chk("wait_pcin", 32'(r_pcin), 1);
    chk("wait_pcin_last", 32'(r_pcin_last), 1);
    chk("wait_rin", 32'(r_rin_last), 32'h0001);

    // memory never ready
    run_instr(100, -1);
    chk("to_cycles", 32'(r_cyc), 16);
    chk("to_reads", 32'(r_read), 15);
    chk("to_flag", 32'(MemTimeout), 1);
    chk("to_run", 32'(Run), 0);
    chk("to_strb", 32'(strb), 0);
    do_clear();
    chk("to_cleared", 32'(MemTimeout), 0);
    tick();

    // undefined opcode 11111
    IR = 32'hF800_0000;
    run_instr(0, -1);
    chk("ill_cycles", 32'(r_cyc), 4);
    chk("ill_rin", 32'(r_rin_n), 0);
    chk("ill_flag", 32'(Illegal), 1);
    chk("ill_refetch", 32'(strb), 32'(B_T0));

    // Clear in T4 of add
    IR = 32'h1822_8000;
    tick(); tick(); tick(); tick();
    chk("clr_pre_rout", 32'(Rout), 32'h0020);
    do_clear();
    expect_cyc("clr", '0, '0, '0, '0, 1'b0);
    chk("clr_illegal", 32'(Illegal), 0);
    tick();
    expect_cyc("clr_t0", B_T0, '0, '0, '0, 1'b1);

    // Stop pulsed in T1 of add
    run_instr(0, 1);
    chk("stop_cycles", 32'(r_cyc), 6);
    chk("stop_rin_n", 32'(r_rin_n), 1);
    chk("stop_rin", 32'(r_rin_last), 32'h0001);
    chk("stop_run", 32'(Run), 0);
    chk("stop_strb", 32'(strb), 0);
    do_clear(); tick();

    // sub R3,R1,R2
    IR = 32'h2189_0000;
    run_instr(0, -1);
    chk("sub_cycles", 32'(r_cyc), 6);
    chk("sub_op", 32'(r_op), 32'h05);
    chk("sub_rin", 32'(r_rin_last), 32'h0008);

    // NOP
    IR = 32'hD000_0000;
    run_instr(0, -1);
    chk("nop_cycles", 32'(r_cyc), 4);
    chk("nop_illegal", 32'(Illegal), 0);
    chk("nop_run", 32'(Run), 1);

    // HALT opcode
    IR = 32'hD800_0000;
    run_instr(0, -1);
    chk("halt_cycles", 32'(r_cyc), 4);
    chk("halt_run", 32'(Run), 0);
    do_clear(); tick();

    // mul R2,R3
    IR = 32'h7918_0000;
    run_instr(0, -1);
`ifdef MULDIV_EN
    chk("mul_cycles", 32'(r_cyc), 7);
    chk("mul_lo", 32'(r_lo), 1);
    chk("mul_hi", 32'(r_hi), 1);
    chk("mul_op", 32'(r_op), 32'h0F);
    chk("mul_illegal", 32'(Illegal), 0);
`else
    chk("mul_cycles", 32'(r_cyc), 4);
    chk("mul_illegal", 32'(Illegal), 1);
    chk("mul_rin", 32'(r_rin_n), 0);
    chk("mul_lohi", 32'(r_lo + r_hi), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
